sobel_window_ctrl: RTL and testbench

SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

---
 rtl/sobel_pkg.sv | 25 ++
 rtl/edge_det.sv | 35 +++
 rtl/sobel_window_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared definitions for the Sobel window controller:
//   state_t    - controller FSM encoding (also exported on the debug port)
//   THR_RESET  - gradient threshold in force after reset
//   CNT_MAX    - saturation value of the 10-bit row/column counters
//   sat_inc()  - saturating 10-bit increment used by both counters
// -----------------------------------------------------------------------------
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    LINE      = 2'd2,
    FRAME_END = 2'd3
  } state_t;

  localparam logic [7:0] THR_RESET = 8'd32;
  localparam logic [9:0] CNT_MAX   = 10'd1023;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/edge_det.sv
// -----------------------------------------------------------------------------
// edge_det
// Single-bit rise/fall detector. The previous-sample register only advances
// on enabled cycles, so a stall never manufactures or swallows an edge.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset (previous sample cleared to 0)
//   ce   - clock enable
//   d    - level to watch
//   rise - d is 1 now and was 0 on the previous enabled cycle
//   fall - d is 0 now and was 1 on the previous enabled cycle
// -----------------------------------------------------------------------------
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      d_q <= 1'b0;
    end else if (ce) begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/sobel_window_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_window_ctrl
// Tracks the position of each incoming pixel inside an H_SIZE x V_SIZE frame,
// flags when a full 3x3 neighbourhood exists, marks border pixels, checks the
// frame geometry and double-buffers the gradient threshold so that a new value
// only takes effect at a frame boundary.
//
// Ports:
//   clk, rst, ce            - clock, sync active-low reset, clock enable
//   in_de/in_hsync/in_vsync - video timing, active high
//   cfg_thr/cfg_valid/cfg_ready - threshold offer handshake
//   col, row                - position of the pixel seen one ce-cycle earlier
//   win_valid               - that pixel has a complete 3x3 window
//   border                  - that pixel is on the outer ring of the frame
//   frame_start             - one-cycle pulse after a vsync rising edge
//   thr_active              - threshold in force for the current frame
//   err_geom                - sticky geometry error for the current frame
//   dbg_state               - controller FSM state
//
// Handshake: cfg_thr is taken on an enabled cycle with cfg_valid & cfg_ready.
// cfg_ready is 1 exactly when no threshold is waiting; the producer holds
// cfg_valid/cfg_thr until it sees the transfer, and may drop valid any time.
// -----------------------------------------------------------------------------
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int H_SIZE = 64,
  parameter int V_SIZE = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       in_de,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic [7:0] cfg_thr,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       win_valid,
  output logic       border,
  output logic       frame_start,
  output logic [7:0] thr_active,
  output logic       err_geom,
  output state_t     dbg_state
);

  localparam logic [9:0] H_CNT  = 10'(H_SIZE);
  localparam logic [9:0] H_LAST = 10'(H_SIZE - 1);
  localparam logic [9:0] V_LAST = 10'(V_SIZE - 1);

  // Line structure is derived from in_de alone; hsync carries nothing extra.
  logic unused_hsync;
  assign unused_hsync = in_hsync;

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  logic de_rise, de_fall;
  logic vs_rise, vs_fall_unused;

  edge_det u_de_edge (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .d    (in_de),
    .rise (de_rise),
    .fall (de_fall)
  );

  edge_det u_vs_edge (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .d    (in_vsync),
    .rise (vs_rise),
    .fall (vs_fall_unused)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t     state_q;
  logic [9:0] col_cnt_q;     // pixels seen so far on the current line
  logic [9:0] row_cnt_q;     // lines completed so far in the current frame
  logic [9:0] col_q;
  logic [9:0] row_q;
  logic       win_valid_q;
  logic       border_q;
  logic       frame_start_q;
  logic       err_q;
  logic [7:0] thr_q;
  logic       pend_q;
  logic [7:0] pend_val_q;

  // ---------------------------------------------------------------------------
  // Per-cycle qualifiers. The frame boundary overrides any in_de edge.
  // ---------------------------------------------------------------------------
  logic boundary;
  logic pix_en;
  logic line_end;
  logic cfg_acc;
  logic pix_win;
  logic pix_border;

  assign boundary = vs_rise;

  // A pixel counts on the first de cycle of a line (rise in WAIT_LINE) and
  // on every de cycle while in LINE. IDLE and FRAME_END never count.
  assign pix_en   = in_de & ~boundary &
                    (((state_q == WAIT_LINE) & de_rise) | (state_q == LINE));
  assign line_end = de_fall & ~boundary & (state_q == LINE);
  assign cfg_acc  = cfg_valid & ~pend_q;

  assign pix_win    = (row_cnt_q >= 10'd2) & (col_cnt_q >= 10'd2);
  assign pix_border = (row_cnt_q == 10'd0) | (row_cnt_q == V_LAST) |
                      (col_cnt_q == 10'd0) | (col_cnt_q == H_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      col_cnt_q     <= 10'd0;
      row_cnt_q     <= 10'd0;
      col_q         <= 10'd0;
      row_q         <= 10'd0;
      win_valid_q   <= 1'b0;
      border_q      <= 1'b0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
      thr_q         <= THR_RESET;
      pend_q        <= 1'b0;
      pend_val_q    <= 8'd0;
    end else if (ce) begin
      frame_start_q <= 1'b0;
      win_valid_q   <= 1'b0;
      border_q      <= 1'b0;

      // A value taken in the boundary cycle itself cannot collide with the
      // copy below: acceptance requires no pending value, so the copy branch
      // is skipped and the new value waits for the next boundary.
      if (cfg_acc) begin
        pend_q     <= 1'b1;
        pend_val_q <= cfg_thr;
      end

      if (boundary) begin
        state_q       <= WAIT_LINE;
        col_cnt_q     <= 10'd0;
        row_cnt_q     <= 10'd0;
        col_q         <= 10'd0;
        row_q         <= 10'd0;
        err_q         <= 1'b0;
        frame_start_q <= 1'b1;
        if (pend_q) begin
          thr_q  <= pend_val_q;
          pend_q <= 1'b0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            // Waits for a frame boundary; in_de is ignored here.
          end
          WAIT_LINE: begin
            if (de_rise) state_q <= LINE;
          end
          LINE: begin
            if (de_fall) state_q <= (row_cnt_q >= V_LAST) ? FRAME_END : WAIT_LINE;
          end
          FRAME_END: begin
            // Any further line after the last one is a geometry error.
            if (de_rise) err_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase

        if (pix_en) begin
          col_q       <= col_cnt_q;
          row_q       <= row_cnt_q;
          win_valid_q <= pix_win;
          border_q    <= pix_border;
          col_cnt_q   <= sat_inc(col_cnt_q);
        end

        // Between lines the outputs show where the next pixel will land.
        if (line_end) begin
          col_cnt_q <= 10'd0;
          row_cnt_q <= sat_inc(row_cnt_q);
          col_q     <= 10'd0;
          row_q     <= sat_inc(row_cnt_q);
          if (col_cnt_q != H_CNT) err_q <= 1'b1;
        end
      end
    end
  end

  assign cfg_ready   = ~pend_q;
  assign col         = col_q;
  assign row         = row_q;
  assign win_valid   = win_valid_q;
  assign border      = border_q;
  assign frame_start = frame_start_q;
  assign thr_active  = thr_q;
  assign err_geom    = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
module tb_sobel_window_ctrl;
  import sobel_pkg::*;

  localparam int H = 8;
  localparam int V = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset / signals
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce = 1'b1;
  logic       in_de = 1'b0;
  logic       in_hsync = 1'b0;
  logic       in_vsync = 1'b0;
  logic [7:0] cfg_thr = 8'd0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [9:0] col, row;
  logic       win_valid, border, frame_start, err_geom;
  logic [7:0] thr_active;
  state_t     dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int fs_seen = 0;
  int wv_seen = 0;

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  sobel_window_ctrl #(.H_SIZE(H), .V_SIZE(V)) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .in_de       (in_de),
    .in_hsync    (in_hsync),
    .in_vsync    (in_vsync),
    .cfg_thr     (cfg_thr),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .col         (col),
    .row         (row),
    .win_valid   (win_valid),
    .border      (border),
    .frame_start (frame_start),
    .thr_active  (thr_active),
    .err_geom    (err_geom),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_start) fs_seen++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive n de cycles on line r starting at column c0; check every pixel.
  task automatic run_pixels(input int r, input int c0, input int n);
    int c;
    for (int i = 0; i < n; i++) begin
      c = c0 + i;
      in_de = 1'b1;
      tick();
      chk($sformatf("px_col r%0d c%0d", r, c), 32'(col), c);
      chk($sformatf("px_row r%0d c%0d", r, c), 32'(row), r);
      chk($sformatf("px_win r%0d c%0d", r, c), 32'(win_valid), 32'(r >= 2 && c >= 2));
      chk($sformatf("px_border r%0d c%0d", r, c), 32'(border),
          32'(r == 0 || r == V - 1 || c == 0 || c == H - 1));
      chk($sformatf("px_state r%0d c%0d", r, c), 32'(dbg_state), 32'(LINE));
      if (win_valid) wv_seen++;
    end
  endtask

  // Drop de after line r, then one blanking cycle.
  task automatic end_line(input int r, input state_t st);
    in_de = 1'b0;
    tick();
    chk($sformatf("eol_col r%0d", r), 32'(col), 0);
    chk($sformatf("eol_row r%0d", r), 32'(row), r + 1);
    chk($sformatf("eol_state r%0d", r), 32'(dbg_state), 32'(st));
    tick();
  endtask

  task automatic full_line(input int r);
    run_pixels(r, 0, H);
    end_line(r, (r == V - 1) ? FRAME_END : WAIT_LINE);
  endtask

  task automatic vsync_pulse(input logic [7:0] exp_thr, input logic exp_rdy);
    in_de = 1'b0;
    in_vsync = 1'b1;
    tick();
    chk("vs_frame_start", 32'(frame_start), 1);
    chk("vs_state", 32'(dbg_state), 32'(WAIT_LINE));
    chk("vs_err_clear", 32'(err_geom), 0);
    chk("vs_col", 32'(col), 0);
    chk("vs_row", 32'(row), 0);
    chk("vs_thr", 32'(thr_active), 32'(exp_thr));
    chk("vs_ready", 32'(cfg_ready), 32'(exp_rdy));
    in_vsync = 1'b0;
    tick();
    chk("vs_pulse_end", 32'(frame_start), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: reset, IDLE ignoring de, first boundary, start of line 0
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rst, ce, de, vs, cv;
    logic [7:0] thr;
    logic [9:0] e_col, e_row;
    logic       e_wv, e_bd, e_fs, e_rdy, e_err;
    logic [7:0] e_thr;
    state_t     e_st;
  } vec_t;

  vec_t tbl[8];

  initial begin
    //          rst   ce    de    vs    cv    thr    col    row    wv    bd    fs    rdy   err   thr    state
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h20, IDLE};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h20, IDLE};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h20, IDLE};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h20, WAIT_LINE};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h20, WAIT_LINE};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, LINE};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 10'd1, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, LINE};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 10'd2, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, LINE};

    // ---- Test 1: nominal frame (table covers reset and first 3 pixels) ----
    fs_seen = 0;
    wv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      rst       = tbl[i].rst;
      ce        = tbl[i].ce;
      in_de     = tbl[i].de;
      in_vsync  = tbl[i].vs;
      cfg_valid = tbl[i].cv;
      cfg_thr   = tbl[i].thr;
      tick();
      chk($sformatf("v%0d_col", i), 32'(col), 32'(tbl[i].e_col));
      chk($sformatf("v%0d_row", i), 32'(row), 32'(tbl[i].e_row));
      chk($sformatf("v%0d_win", i), 32'(win_valid), 32'(tbl[i].e_wv));
      chk($sformatf("v%0d_border", i), 32'(border), 32'(tbl[i].e_bd));
      chk($sformatf("v%0d_fs", i), 32'(frame_start), 32'(tbl[i].e_fs));
      chk($sformatf("v%0d_ready", i), 32'(cfg_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_err", i), 32'(err_geom), 32'(tbl[i].e_err));
      chk($sformatf("v%0d_thr", i), 32'(thr_active), 32'(tbl[i].e_thr));
      chk($sformatf("v%0d_state", i), 32'(dbg_state), 32'(tbl[i].e_st));
    end
    cfg_valid = 1'b0;
    run_pixels(0, 3, H - 3);
    end_line(0, WAIT_LINE);
    for (int r = 1; r < V; r++) full_line(r);
    chk("t1_win_count", wv_seen, 12);
    chk("t1_fs_count", fs_seen, 1);
    chk("t1_err", 32'(err_geom), 0);

    // ---- Test 2: short second line ----
    vsync_pulse(8'h20, 1'b1);
    full_line(0);
    run_pixels(1, 0, H - 1);
    chk("t2_err_before_fall", 32'(err_geom), 0);
    end_line(1, WAIT_LINE);
    chk("t2_err_after_fall", 32'(err_geom), 1);
    full_line(2);
    full_line(3);
    chk("t2_err_sticky", 32'(err_geom), 1);
    vsync_pulse(8'h20, 1'b1);  // err_geom clears at this boundary

    // ---- Test 3: configuration accepted mid-frame ----
    full_line(0);
    cfg_valid = 1'b1;
    cfg_thr   = 8'h50;
    tick();
    cfg_valid = 1'b0;
    chk("t3_ready_low", 32'(cfg_ready), 0);
    chk("t3_thr_old", 32'(thr_active), 32'h20);
    for (int r = 1; r < V; r++) full_line(r);
    chk("t3_thr_hold", 32'(thr_active), 32'h20);
    chk("t3_ready_hold", 32'(cfg_ready), 0);
    vsync_pulse(8'h50, 1'b1);

    // ---- Test 4: config in boundary cycle, plus de in FRAME_END ----
    for (int r = 0; r < V; r++) full_line(r);
    in_de = 1'b1;
    tick();
    chk("t4_extra_line_err", 32'(err_geom), 1);
    chk("t4_extra_line_state", 32'(dbg_state), 32'(FRAME_END));
    chk("t4_extra_line_col", 32'(col), 0);
    in_de = 1'b0;
    tick();
    in_vsync  = 1'b1;
    cfg_valid = 1'b1;
    cfg_thr   = 8'h60;
    tick();
    chk("t4_bnd_fs", 32'(frame_start), 1);
    chk("t4_bnd_thr", 32'(thr_active), 32'h50);
    chk("t4_bnd_ready", 32'(cfg_ready), 0);
    chk("t4_bnd_err", 32'(err_geom), 0);
    in_vsync  = 1'b0;
    cfg_valid = 1'b0;
    tick();
    for (int r = 0; r < V; r++) full_line(r);
    chk("t4_thr_frame", 32'(thr_active), 32'h50);
    vsync_pulse(8'h60, 1'b1);

    // ---- Test 5: clock enable low mid-line ----
    run_pixels(0, 0, 4);
    ce        = 1'b0;
    cfg_valid = 1'b1;
    cfg_thr   = 8'h33;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t5_col k%0d", k), 32'(col), 3);
      chk($sformatf("t5_row k%0d", k), 32'(row), 0);
      chk($sformatf("t5_border k%0d", k), 32'(border), 1);
      chk($sformatf("t5_ready k%0d", k), 32'(cfg_ready), 1);
      chk($sformatf("t5_state k%0d", k), 32'(dbg_state), 32'(LINE));
    end
    ce        = 1'b1;
    cfg_valid = 1'b0;
    run_pixels(0, 4, H - 4);
    end_line(0, WAIT_LINE);
    chk("t5_no_lost_pixels", 32'(err_geom), 0);
    chk("t5_thr", 32'(thr_active), 32'h60);

    // ---- Test 6: reset mid-frame with a pending threshold ----
    full_line(1);
    cfg_valid = 1'b1;
    cfg_thr   = 8'h70;
    tick();
    cfg_valid = 1'b0;
    chk("t6_pending", 32'(cfg_ready), 0);
    run_pixels(2, 0, 4);
    rst = 1'b0;
    tick();
    chk("t6_rst_col", 32'(col), 0);
    chk("t6_rst_row", 32'(row), 0);
    chk("t6_rst_win", 32'(win_valid), 0);
    chk("t6_rst_border", 32'(border), 0);
    chk("t6_rst_fs", 32'(frame_start), 0);
    chk("t6_rst_err", 32'(err_geom), 0);
    chk("t6_rst_thr", 32'(thr_active), 32'h20);
    chk("t6_rst_ready", 32'(cfg_ready), 1);
    chk("t6_rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < H; i++) begin
        in_de = 1'b1;
        tick();
        chk($sformatf("t6_ign_col l%0d i%0d", l, i), 32'(col), 0);
        chk($sformatf("t6_ign_win l%0d i%0d", l, i), 32'(win_valid), 0);
        chk($sformatf("t6_ign_state l%0d i%0d", l, i), 32'(dbg_state), 32'(IDLE));
      end
      in_de = 1'b0;
      tick();
      chk($sformatf("t6_ign_row l%0d", l), 32'(row), 0);
    end
    vsync_pulse(8'h20, 1'b1);
    full_line(0);
    chk("t6_resume_err", 32'(err_geom), 0);
    chk("t6_thr_final", 32'(thr_active), 32'h20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
